// File: rtl/uart_tx_pkg.sv
// Shared state encoding and byte constants for the result-to-ASCII UART streamer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    LOAD,
    START,
    WAIT_HI,
    WAIT_LO,
    GAP,
    FINISH
  } tx_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Byte index space: 0..4 = d4..d0, then CR, then LF.
  localparam logic [2:0] IDX_ONES = 3'd4;
  localparam logic [2:0] IDX_CR   = 3'd5;
  localparam logic [2:0] IDX_LF   = 3'd6;

  // Index of the first digit to send; the ones digit is always sent.
  function automatic logic [2:0] first_digit(input logic [19:0] bcd, input logic suppress);
    logic [2:0] idx;
    logic       found;
    idx   = IDX_ONES;
    found = 1'b0;
    if (!suppress) begin
      idx = 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!found && bcd[19-4*i -: 4] != 4'd0) begin
          idx   = 3'(i);
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bin16_to_bcd.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits.
// Latency 17 cycles from start to the done pulse; a new start restarts the conversion.
module bin16_to_bcd (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] bin_sr;
  logic [19:0] bcd_sr;
  logic [19:0] bcd_adj;
  logic [4:0]  shift_cnt;
  logic        running;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 5; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bin_sr    <= '0;
      bcd_sr    <= '0;
      shift_cnt <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin_sr    <= bin;
        bcd_sr    <= '0;
        shift_cnt <= 5'd16;
        running   <= 1'b1;
      end else if (running) begin
        if (shift_cnt != 5'd0) begin
          {bcd_sr, bin_sr} <= {bcd_adj[18:0], bin_sr, 1'b0};
          shift_cnt        <= shift_cnt - 5'd1;
        end else begin
          bcd     <= bcd_sr;
          done    <= 1'b1;
          running <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/uart_result_ascii_tx.sv
// Captures a 16-bit result on trigger and streams it as decimal ASCII (+CR/LF) to a byte UART.
// One byte per tx_start; waits for tx_busy to rise (with timeout) and fall, then an idle gap.
module uart_result_ascii_tx
  import uart_tx_pkg::*;
#(
  parameter int INTER_BYTE_DELAY = 1000000,
  parameter int BUSY_TIMEOUT     = 16,
  parameter int SEND_CRLF        = 1,
  parameter int SUPPRESS_ZEROS   = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        trigger,
  input  logic [15:0] resultado,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        done
);

  localparam int DLY_W = $clog2(INTER_BYTE_DELAY + 1);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(INTER_BYTE_DELAY - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [2:0] LAST_IDX = (SEND_CRLF != 0) ? IDX_LF : IDX_ONES;

  tx_state_t        state;
  logic [15:0]      value_q;
  logic [19:0]      digits;
  logic [2:0]       byte_idx;
  logic [DLY_W-1:0] dly_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             conv_start;
  logic             conv_done;
  logic [19:0]      conv_bcd;
  logic [7:0]       next_byte;

  bin16_to_bcd u_bcd (
    .clk    (clk),
    .resetN (resetN),
    .start  (conv_start),
    .bin    (value_q),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  always_comb begin
    next_byte = ASCII_LF;
    case (byte_idx)
      3'd0:    next_byte = ASCII_ZERO + {4'h0, digits[19:16]};
      3'd1:    next_byte = ASCII_ZERO + {4'h0, digits[15:12]};
      3'd2:    next_byte = ASCII_ZERO + {4'h0, digits[11:8]};
      3'd3:    next_byte = ASCII_ZERO + {4'h0, digits[7:4]};
      3'd4:    next_byte = ASCII_ZERO + {4'h0, digits[3:0]};
      3'd5:    next_byte = ASCII_CR;
      default: next_byte = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      value_q    <= '0;
      digits     <= '0;
      byte_idx   <= '0;
      dly_cnt    <= '0;
      to_cnt     <= '0;
      conv_start <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      tx_start   <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            value_q    <= resultado;
            conv_start <= 1'b1;
            busy       <= 1'b1;
            state      <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            digits   <= conv_bcd;
            byte_idx <= first_digit(conv_bcd, SUPPRESS_ZEROS != 0);
            state    <= LOAD;
          end
        end
        LOAD: begin
          // A late-rising busy after a timeout must not overlap a new start.
          if (!tx_busy) begin
            tx_data  <= next_byte;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (to_cnt == TO_LAST) begin
            dly_cnt <= '0;
            state   <= GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            dly_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (dly_cnt == DLY_LAST) begin
            if (byte_idx == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FINISH;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= LOAD;
            end
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_ascii_tx.sv
// Directed bench: two DUTs (leading-zero suppression on/off) with a simple busy-pulse UART model.
module tb_uart_result_ascii_tx;

  logic        clk = 1'b0;
  logic        resetN;
  logic [15:0] resultado;
  logic        trig     [2];
  logic        tx_busy  [2];
  logic [7:0]  tx_data  [2];
  logic        tx_start [2];
  logic        busy     [2];
  logic        done     [2];
  logic        uart_en  [2];
  int unsigned ucnt     [2] = '{0, 0};

  always #5 clk = ~clk;

  uart_result_ascii_tx #(
    .INTER_BYTE_DELAY (20),
    .BUSY_TIMEOUT     (16),
    .SEND_CRLF        (1),
    .SUPPRESS_ZEROS   (1)
  ) u_dut (
    .clk       (clk),
    .resetN    (resetN),
    .trigger   (trig[0]),
    .resultado (resultado),
    .tx_busy   (tx_busy[0]),
    .tx_data   (tx_data[0]),
    .tx_start  (tx_start[0]),
    .busy      (busy[0]),
    .done      (done[0])
  );

  uart_result_ascii_tx #(
    .INTER_BYTE_DELAY (20),
    .BUSY_TIMEOUT     (16),
    .SEND_CRLF        (1),
    .SUPPRESS_ZEROS   (0)
  ) u_dut_nz (
    .clk       (clk),
    .resetN    (resetN),
    .trigger   (trig[1]),
    .resultado (resultado),
    .tx_busy   (tx_busy[1]),
    .tx_data   (tx_data[1]),
    .tx_start  (tx_start[1]),
    .busy      (busy[1]),
    .done      (done[1])
  );

  // UART model: busy rises the cycle after tx_start and stays high 50 cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_start[i] && uart_en[i]) ucnt[i] <= 50;
      else if (ucnt[i] != 0)         ucnt[i] <= ucnt[i] - 1;
    end
  end
  assign tx_busy[0] = (ucnt[0] != 0);
  assign tx_busy[1] = (ucnt[1] != 0);

  // Monitor on the selected DUT.
  logic       sel;
  logic       m_start, m_txbusy;
  logic [7:0] m_data;
  always_comb begin
    m_start  = tx_start[sel];
    m_txbusy = tx_busy[sel];
    m_data   = tx_data[sel];
  end

  int         cyc = 0;
  logic [7:0] rx_q [$];
  int         start_cyc [$];
  int         start_busy_viol = 0;
  int         data_viol = 0;
  logic [7:0] held = 8'h00;
  bit         track = 1'b0;
  bit         seen_hi = 1'b0;
  int         age = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_start) begin
      rx_q.push_back(m_data);
      start_cyc.push_back(cyc);
      if (m_txbusy) start_busy_viol++;
      held    = m_data;
      track   = 1'b1;
      seen_hi = 1'b0;
      age     = 0;
    end else if (track) begin
      if (m_data != held) data_viol++;
      age++;
      if (m_txbusy) seen_hi = 1'b1;
      else if (seen_hi || age > 20) track = 1'b0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [7:0] exp_q [$];

  task automatic run_msg(input logic inst, input logic [15:0] val, input int retrig_at,
                         input int exp_gap, input string tag);
    int  base, v0, d0, drop;
    bit  got_done, busy_at_done, retrig_done;
    sel  = inst;
    base = rx_q.size();
    v0   = start_busy_viol;
    d0   = data_viol;
    @(negedge clk);
    resultado = val;
    trig[inst] = 1'b1;
    @(negedge clk);
    trig[inst] = 1'b0;
    drop = 0; got_done = 1'b0; busy_at_done = 1'b1; retrig_done = 1'b0;
    for (int k = 0; k < 3000 && !got_done; k++) begin
      if (done[inst]) begin
        got_done     = 1'b1;
        busy_at_done = busy[inst];
      end else begin
        if (!busy[inst]) drop++;
        if (retrig_at >= 0 && !retrig_done && rx_q.size() - base == retrig_at) begin
          resultado   = 16'd7;
          trig[inst]  = 1'b1;
          retrig_done = 1'b1;
        end else begin
          trig[inst] = 1'b0;
        end
        @(negedge clk);
      end
    end
    trig[inst] = 1'b0;
    check({tag, "_done_seen"}, 32'(got_done), 1);
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
    check({tag, "_busy_drops"}, drop, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done[inst]), 0);
    check({tag, "_len"}, rx_q.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < rx_q.size())
        check($sformatf("%s_byte%0d", tag, k), 32'(rx_q[base+k]), 32'(exp_q[k]));
    end
    if (rx_q.size() - base >= 2)
      check({tag, "_start_spacing"}, start_cyc[base+1] - start_cyc[base], exp_gap);
    check({tag, "_start_while_busy"}, start_busy_viol - v0, 0);
    check({tag, "_data_stable"}, data_viol - d0, 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int  base, n;
    bit  reached;
    resetN     = 1'b0;
    resultado  = 16'd0;
    trig[0]    = 1'b0;
    trig[1]    = 1'b0;
    uart_en[0] = 1'b1;
    uart_en[1] = 1'b1;
    sel        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start[0]), 0);
    check("rst_tx_data", 32'(tx_data[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A};
    run_msg(1'b0, 16'd12345, -1, 73, "t1_12345");

    exp_q = '{8'h30, 8'h0D, 8'h0A};
    run_msg(1'b0, 16'd0, -1, 73, "t2_zero");

    exp_q = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0D, 8'h0A};
    run_msg(1'b0, 16'd65535, -1, 73, "t2_65535");

    exp_q = '{8'h30, 8'h30, 8'h31, 8'h30, 8'h30, 8'h0D, 8'h0A};
    run_msg(1'b1, 16'd100, -1, 73, "t3_nz_100");

    exp_q = '{8'h31, 8'h30, 8'h30, 8'h0D, 8'h0A};
    run_msg(1'b0, 16'd100, -1, 73, "t3_sz_100");

    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A};
    run_msg(1'b0, 16'd12345, 2, 73, "t4_retrig");

    // Reset during WAIT_LO of the third byte.
    sel  = 1'b0;
    base = rx_q.size();
    @(negedge clk);
    resultado = 16'd12345;
    trig[0]   = 1'b1;
    @(negedge clk);
    trig[0] = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 2000 && !reached; k++) begin
      @(negedge clk);
      if (rx_q.size() - base >= 3 && tx_busy[0]) reached = 1'b1;
    end
    check("t5_reach_byte3", 32'(reached), 1);
    repeat (5) @(negedge clk);
    check("t5_busy_before_rst", 32'(busy[0]), 1);
    resetN = 1'b0;
    #1;
    check("t5_rst_tx_start", 32'(tx_start[0]), 0);
    check("t5_rst_busy", 32'(busy[0]), 0);
    check("t5_rst_done", 32'(done[0]), 0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    n = rx_q.size();
    repeat (400) @(negedge clk);
    check("t5_no_resume", rx_q.size() - n, 0);
    check("t5_idle_busy", 32'(busy[0]), 0);

    // UART that never answers: each byte times out then takes the gap.
    uart_en[0] = 1'b0;
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A};
    run_msg(1'b0, 16'd12345, -1, 38, "t6_timeout");
    uart_en[0] = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
